// File: rtl/dm_be_ctrl.sv
// Byte-addressed MEM-stage data memory with lane-enabled stores, extending loads,
// misalignment / illegal-mode detection and a one-word-per-cycle clear engine after reset.
module dm_be_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [31:0]           din,
  input  logic                  we,
  input  logic [2:0]            mode,
  output logic [31:0]           dout,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [1:0]              lane_s;
  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_idx_s;
  logic [3:0]              wr_mask_s;
  logic [31:0]             wr_data_s;
  logic [31:0]             rd_word_s;
  logic [15:0]             rd_half_s;
  logic [7:0]              rd_byte_s;

  assign idx_s  = addr[ADDR_WIDTH+1:2];
  assign lane_s = addr[1:0];
  assign busy   = (state_q == ST_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == PTR_LAST) state_d = ST_IDLE;
        else                       state_d = ST_CLEAR;
      end
      ST_IDLE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err = 1'b0;
    case (mode)
      3'b000:         err = (lane_s != 2'b00);
      3'b001, 3'b010: err = addr[0];
      3'b011, 3'b100: err = 1'b0;
      default:        err = 1'b1;
    endcase
  end

  // The clear engine owns the write port while busy; user stores are dropped.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_mask_s = 4'b0000;
    wr_data_s = din;
    if (busy) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = clr_ptr_q;
      wr_mask_s = 4'b1111;
      wr_data_s = 32'h0000_0000;
    end else if (we && !err) begin
      wr_en_s = 1'b1;
      case (mode)
        3'b000: wr_mask_s = 4'b1111;
        3'b001, 3'b010: begin
          wr_mask_s = addr[1] ? 4'b1100 : 4'b0011;
          wr_data_s = {2{din[15:0]}};
        end
        3'b011, 3'b100: begin
          wr_mask_s = 4'b0001 << lane_s;
          wr_data_s = {4{din[7:0]}};
        end
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask_s[i]) mem[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word_s = mem[idx_s];
    rd_half_s = addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (lane_s)
      2'd0:    rd_byte_s = rd_word_s[7:0];
      2'd1:    rd_byte_s = rd_word_s[15:8];
      2'd2:    rd_byte_s = rd_word_s[23:16];
      2'd3:    rd_byte_s = rd_word_s[31:24];
      default: rd_byte_s = rd_word_s[7:0];
    endcase
  end

  always_comb begin
    dout = 32'h0000_0000;
    if (busy || err) begin
      dout = 32'h0000_0000;
    end else begin
      case (mode)
        3'b000:  dout = rd_word_s;
        3'b001:  dout = {{16{rd_half_s[15]}}, rd_half_s};
        3'b010:  dout = {16'h0000, rd_half_s};
        3'b011:  dout = {{24{rd_byte_s[7]}}, rd_byte_s};
        3'b100:  dout = {24'h00_0000, rd_byte_s};
        default: dout = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_be_ctrl.sv
// Directed scoreboard bench for dm_be_ctrl: one clearing instance and one
// non-clearing instance sharing stimulus.
module tb_dm_be_ctrl;

  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic [AW+1:0] addr;
  logic [31:0]   din;
  logic          we;
  logic [2:0]    mode;
  logic [31:0]   dout, dout_nc;
  logic          busy, busy_nc;
  logic          err, err_nc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          nc;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb_q[$];

  dm_be_ctrl #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .mode(mode),
    .dout(dout), .busy(busy), .err(err)
  );

  dm_be_ctrl #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .mode(mode),
    .dout(dout_nc), .busy(busy_nc), .err(err_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [AW+1:0] a, input logic [2:0] m, input logic [31:0] d);
    @(negedge clk);
    addr = a; mode = m; din = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic load_chk(input string tag, input bit nc, input logic [AW+1:0] a,
                          input logic [2:0] m, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    @(negedge clk);
    addr = a; mode = m; we = 1'b0;
    sb_q.push_back('{tag: tag, nc: nc, d: exp_d, e: exp_e});
    #2;
    e = sb_q.pop_front();
    check({e.tag, "_dout"}, e.nc ? dout_nc : dout, e.d);
    check({e.tag, "_err"}, {31'd0, e.nc ? err_nc : err}, {31'd0, e.e});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; din = 32'h0; mode = 3'b000;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_busy_nc", {31'd0, busy_nc}, 32'd0);
    check("rst_dout", dout, 32'h0);

    // Clear with a blocked store held active throughout
    @(negedge clk);
    reset = 1'b0; we = 1'b1; addr = 6'h00; mode = 3'b000; din = 32'hFFFF_FFFF;
    count_busy(n);
    we = 1'b0;
    check("clear_edges", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) load_chk("clear_lw", 1'b0, 6'(i * 4), 3'b000, 32'h0, 1'b0);

    // Word and byte stores
    store(6'h08, 3'b000, 32'h1122_3344);
    store(6'h09, 3'b011, 32'h0000_00AA);
    load_chk("lw_08", 1'b0, 6'h08, 3'b000, 32'h1122_AA44, 1'b0);
    load_chk("lbu_09", 1'b0, 6'h09, 3'b100, 32'h0000_00AA, 1'b0);
    load_chk("lb_09", 1'b0, 6'h09, 3'b011, 32'hFFFF_FFAA, 1'b0);
    store(6'h0B, 3'b100, 32'hFFFF_FF7F);
    load_chk("lw_08_b3", 1'b0, 6'h08, 3'b000, 32'h7F22_AA44, 1'b0);
    load_chk("lb_0b", 1'b0, 6'h0B, 3'b011, 32'h0000_007F, 1'b0);

    // Halfword store and extending loads
    store(6'h0E, 3'b001, 32'h0000_8001);
    load_chk("lh_0e", 1'b0, 6'h0E, 3'b001, 32'hFFFF_8001, 1'b0);
    load_chk("lhu_0e", 1'b0, 6'h0E, 3'b010, 32'h0000_8001, 1'b0);
    load_chk("lw_0c", 1'b0, 6'h0C, 3'b000, 32'h8001_0000, 1'b0);
    store(6'h0C, 3'b010, 32'hABCD_7FFE);
    load_chk("lw_0c_lo", 1'b0, 6'h0C, 3'b000, 32'h8001_7FFE, 1'b0);
    load_chk("lh_0c", 1'b0, 6'h0C, 3'b001, 32'h0000_7FFE, 1'b0);

    // Misalignment and illegal mode
    load_chk("sw_05_err", 1'b0, 6'h05, 3'b000, 32'h0, 1'b1);
    store(6'h05, 3'b000, 32'hDEAD_BEEF);
    load_chk("lw_04_kept", 1'b0, 6'h04, 3'b000, 32'h0, 1'b0);
    load_chk("lh_03_err", 1'b0, 6'h03, 3'b001, 32'h0, 1'b1);
    store(6'h0D, 3'b001, 32'h0000_5555);
    load_chk("lw_0c_kept", 1'b0, 6'h0C, 3'b000, 32'h8001_7FFE, 1'b0);
    load_chk("mode101_err", 1'b0, 6'h08, 3'b101, 32'h0, 1'b1);
    load_chk("mode111_err", 1'b0, 6'h08, 3'b111, 32'h0, 1'b1);
    load_chk("lbu_0f_ok", 1'b0, 6'h0F, 3'b100, 32'h0000_0080, 1'b0);

    // Read-during-write returns old data before the edge
    @(negedge clk);
    addr = 6'h14; mode = 3'b000; din = 32'hCAFE_F00D; we = 1'b1;
    #1 check("rdw_old", dout, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;
    check("rdw_new", dout, 32'hCAFE_F00D);

    // Reset mid-clear, and retention on the non-clearing instance
    store(6'h10, 3'b000, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rst2_busy", {31'd0, busy}, 32'd1);
    check("rst2_busy_nc", {31'd0, busy_nc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_dout", dout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    check("restart_edges", 32'(n), 32'd16);
    load_chk("nc_lw_10", 1'b1, 6'h10, 3'b000, 32'h1234_5678, 1'b0);
    load_chk("nc_lw_14", 1'b1, 6'h14, 3'b000, 32'hCAFE_F00D, 1'b0);
    load_chk("cl_lw_10", 1'b0, 6'h10, 3'b000, 32'h0, 1'b0);
    load_chk("cl_lw_14", 1'b0, 6'h14, 3'b000, 32'h0, 1'b0);
    load_chk("cl_lw_3c", 1'b0, 6'h3C, 3'b000, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
